// File: rtl/ext_mem_responder.sv
// ext_mem_responder: external-bus memory responder with code store, data RAM and programmable read latency
module ext_mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int CODE_DEPTH = 4096,
  parameter int DATA_DEPTH = 256,
  parameter int READ_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_bus,
  inout  wire  [7:0]        data_bus,
  input  logic              read_en,
  input  logic              write_en,
  input  logic              PSEN,
  input  logic              memory_select,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              drive_en,
  output logic              mem_ready,
  output logic              bus_err
);
  localparam int CW  = $clog2(CODE_DEPTH);
  localparam int DW  = $clog2(DATA_DEPTH);
  localparam int LAT = (READ_LAT < 1) ? 1 : READ_LAT;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_cnt, w_cnt;
  logic [7:0] r_rd_q, w_rd_q;
  logic       r_mem_ready, r_bus_err, w_err, w_we;
  logic [7:0] r_code [CODE_DEPTH];
  logic [7:0] r_data [DATA_DEPTH];
  logic       w_code, w_data, w_code_ok, w_data_ok, w_load_ok;
  logic [7:0] w_byte;
  assign w_code    = !PSEN;
  assign w_data    = PSEN && memory_select;
  assign w_code_ok = 32'(addr_bus) < 32'(CODE_DEPTH);
  assign w_data_ok = 32'(addr_bus) < 32'(DATA_DEPTH);
  assign w_load_ok = 32'(load_addr) < 32'(CODE_DEPTH);
  assign w_byte    = w_code ? (w_code_ok ? r_code[addr_bus[CW-1:0]] : 8'hFF)
                            : (w_data_ok ? r_data[addr_bus[DW-1:0]] : 8'hFF);
  assign drive_en  = (r_state == RD_DRIVE) && read_en;
  assign data_bus  = drive_en ? r_rd_q : 8'hzz;
  assign mem_ready = r_mem_ready;
  assign bus_err   = r_bus_err;
  // next state, latched read byte, latency counter and error/write decisions
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_rd_q = r_rd_q;
    w_err  = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      IDLE: begin
        if (read_en && write_en) w_err = 1'b1;
        else if (read_en && (w_code || w_data)) begin
          w_next = RD_WAIT;
          w_cnt  = 4'(LAT - 1);
          w_rd_q = w_byte;
          w_err  = w_code ? !w_code_ok : !w_data_ok;
        end else if (write_en && (w_code || w_data)) begin
          w_next = WR;
          w_we   = w_data && w_data_ok;
          w_err  = !(w_data && w_data_ok);
        end
      end
      RD_WAIT: begin
        if (!read_en) w_next = IDLE;
        else if (r_cnt == 4'd0) w_next = RD_DRIVE;
        else w_cnt = r_cnt - 4'd1;
      end
      RD_DRIVE: w_next = read_en ? RD_DRIVE : IDLE;
      WR:       w_next = write_en ? WR : IDLE;
      default:  w_next = IDLE;
    endcase
  end
  // state and datapath registers; ready is registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_rd_q      <= 8'h00;
      r_mem_ready <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_rd_q      <= w_rd_q;
      r_mem_ready <= (w_next == RD_DRIVE);
      r_bus_err   <= w_err;
    end
  end
  // memory arrays survive reset; preload works in every state
  always_ff @(posedge clk) begin
    if (load_en && w_load_ok) r_code[load_addr[CW-1:0]] <= load_data;
    if (w_we) r_data[addr_bus[DW-1:0]] <= data_bus;
  end
endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder: randomized self-checking bench with a memory-level reference model
module tb_ext_mem_responder;
  logic        clk = 1'b0, reset = 1'b0;
  logic [15:0] addr_bus = '0, load_addr = '0;
  logic        read_en = 1'b0, write_en = 1'b0, PSEN = 1'b1, memory_select = 1'b0, load_en = 1'b0;
  logic [7:0]  load_data = '0, tb_d = '0;
  logic        tb_oe = 1'b0;
  wire  [7:0]  bus0, bus1, bus2, bus3;
  wire  [3:0]  drv, rdy, err;
  int          checks = 0, errors = 0;
  logic [7:0]  code_m [4096];
  logic [7:0]  data_m [256];

  assign bus0 = tb_oe ? tb_d : 8'hzz;
  assign bus1 = tb_oe ? tb_d : 8'hzz;
  assign bus2 = tb_oe ? tb_d : 8'hzz;
  assign bus3 = tb_oe ? tb_d : 8'hzz;

  ext_mem_responder #(.READ_LAT(2)) u0 (.clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(bus0),
    .read_en(read_en), .write_en(write_en), .PSEN(PSEN), .memory_select(memory_select), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .drive_en(drv[0]), .mem_ready(rdy[0]), .bus_err(err[0]));
  ext_mem_responder #(.READ_LAT(1)) u1 (.clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(bus1),
    .read_en(read_en), .write_en(write_en), .PSEN(PSEN), .memory_select(memory_select), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .drive_en(drv[1]), .mem_ready(rdy[1]), .bus_err(err[1]));
  ext_mem_responder #(.READ_LAT(15)) u2 (.clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(bus2),
    .read_en(read_en), .write_en(write_en), .PSEN(PSEN), .memory_select(memory_select), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .drive_en(drv[2]), .mem_ready(rdy[2]), .bus_err(err[2]));
  ext_mem_responder #(.READ_LAT(0)) u3 (.clk(clk), .reset(reset), .addr_bus(addr_bus), .data_bus(bus3),
    .read_en(read_en), .write_en(write_en), .PSEN(PSEN), .memory_select(memory_select), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .drive_en(drv[3]), .mem_ready(rdy[3]), .bus_err(err[3]));

  always #5 clk = ~clk;

  task automatic do_load(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    if (a < 16'd4096) code_m[a[11:0]] = d;
  endtask

  task automatic do_write(input string nm, input bit psen, input bit msel, input logic [15:0] a,
                          input logic [7:0] d, input int hold, input bit exp_err);
    @(negedge clk);
    PSEN = psen; memory_select = msel; addr_bus = a; tb_d = d; tb_oe = 1'b1; write_en = 1'b1; read_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (err[0] !== exp_err) begin errors++; $display("FAIL %s bus_err got %b want %b", nm, err[0], exp_err); end
    tb_d = ~d;
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    write_en = 1'b0; tb_oe = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (err[0] !== 1'b0) begin errors++; $display("FAIL %s bus_err_pulse got %b want 0", nm, err[0]); end
    if (psen && msel && a < 16'd256) data_m[a[7:0]] = d;
  endtask

  task automatic do_read(input string nm, input bit code, input logic [15:0] a,
                         input bit ld = 1'b0, input logic [7:0] ldd = 8'h00);
    int         want [4];
    int         first [4];
    logic [7:0] got [4];
    bit         oor;
    logic [7:0] expv;
    want = '{3, 2, 16, 2};
    first = '{0, 0, 0, 0};
    oor = code ? (a >= 16'd4096) : (a >= 16'd256);
    expv = oor ? 8'hFF : (code ? code_m[a[11:0]] : data_m[a[7:0]]);
    @(negedge clk);
    PSEN = !code; memory_select = code ? 1'($urandom_range(0, 1)) : 1'b1;
    addr_bus = a; read_en = 1'b1; write_en = 1'b0;
    if (ld) begin load_en = 1'b1; load_addr = a; load_data = ldd; end
    for (int e = 1; e <= 20 && (first[0] == 0 || first[1] == 0 || first[2] == 0 || first[3] == 0); e++) begin
      @(posedge clk); #1;
      load_en = 1'b0;
      if (e <= 2) begin
        checks++;
        if (err[0] !== (e == 1 && oor)) begin errors++; $display("FAIL %s bus_err edge %0d got %b want %b", nm, e, err[0], (e == 1 && oor)); end
      end
      checks++;
      if (rdy[0] !== drv[0]) begin errors++; $display("FAIL %s mem_ready edge %0d got %b want %b", nm, e, rdy[0], drv[0]); end
      got[0] = bus0; got[1] = bus1; got[2] = bus2; got[3] = bus3;
      for (int k = 0; k < 4; k++)
        if (drv[k] && first[k] == 0) begin
          first[k] = e;
          checks++;
          if (got[k] !== expv) begin errors++; $display("FAIL %s data u%0d got %h want %h", nm, k, got[k], expv); end
        end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (first[k] != want[k]) begin errors++; $display("FAIL %s latency u%0d got %0d want %0d", nm, k, first[k], want[k]); end
    end
    @(negedge clk);
    checks++;
    if (drv[0] !== 1'b1 || bus0 !== expv) begin errors++; $display("FAIL %s hold got %b/%h want 1/%h", nm, drv[0], bus0, expv); end
    read_en = 1'b0; #1;
    checks++;
    if (drv !== 4'b0) begin errors++; $display("FAIL %s release got %b want 0000", nm, drv); end
    @(posedge clk); #1;
    checks++;
    if (rdy !== 4'b0) begin errors++; $display("FAIL %s ready_drop got %b want 0000", nm, rdy); end
    if (ld && !oor) code_m[a[11:0]] = ldd;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({drv, rdy, err} !== 12'b0) begin errors++; $display("FAIL reset outputs got %b want 0", {drv, rdy, err}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    do_load(16'h0000, 8'h0B);
    do_load(16'h0001, 8'h1A);
    do_read("fetch0", 1'b1, 16'h0000);
    do_read("fetch1", 1'b1, 16'h0001);
  endtask

  task automatic test_data_write();
    do_write("wr42", 1'b1, 1'b1, 16'h0042, 8'h5A, 5, 1'b0);
    do_read("rd42", 1'b0, 16'h0042);
  endtask

  task automatic test_errors();
    do_read("oor_code", 1'b1, 16'h1000);
    do_read("oor_data", 1'b0, 16'h0100);
    do_write("wr_code", 1'b0, 1'b0, 16'h0000, 8'h77, 2, 1'b1);
    do_read("code0_kept", 1'b1, 16'h0000);
    do_write("wr_oor", 1'b1, 1'b1, 16'h0100, 8'h33, 1, 1'b1);
    do_write("wr_none", 1'b1, 1'b0, 16'h0042, 8'h99, 1, 1'b0);
    do_read("rd42_after", 1'b0, 16'h0042);
    do_load(16'h1000, 8'hEE);
    do_read("no_alias", 1'b1, 16'h0000);
  endtask

  task automatic test_abort();
    @(negedge clk);
    PSEN = 1'b1; memory_select = 1'b1; addr_bus = 16'h0042; read_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    read_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (drv !== 4'b0 || rdy !== 4'b0) begin errors++; $display("FAIL abort cycle %0d got %b/%b want 0", i, drv, rdy); end
    end
    do_read("after_abort", 1'b0, 16'h0042);
  endtask

  task automatic test_both();
    @(negedge clk);
    PSEN = 1'b1; memory_select = 1'b1; addr_bus = 16'h0042; tb_d = 8'hC3; tb_oe = 1'b1;
    read_en = 1'b1; write_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (err[0] !== 1'b1) begin errors++; $display("FAIL both bus_err got %b want 1", err[0]); end
    @(negedge clk);
    read_en = 1'b0; write_en = 1'b0; tb_oe = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (err[0] !== 1'b0 || drv !== 4'b0) begin errors++; $display("FAIL both after got %b/%b want 0", err[0], drv); end
    do_read("both_nochg", 1'b0, 16'h0042);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(negedge clk);
    PSEN = 1'b1; memory_select = 1'b1; addr_bus = 16'h0042; read_en = 1'b1;
    while (!drv[0] && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (drv[0] !== 1'b1) begin errors++; $display("FAIL rst_mid reach_drive got %b want 1", drv[0]); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({drv, rdy, err} !== 12'b0) begin errors++; $display("FAIL rst_mid outputs got %b want 0", {drv, rdy, err}); end
    @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_read("post_reset", 1'b0, 16'h0042);
  endtask

  task automatic test_load_race();
    do_load(16'h0005, 8'h21);
    do_read("race_old", 1'b1, 16'h0005, 1'b1, 8'h84);
    do_read("race_new", 1'b1, 16'h0005);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 32; i++) do_write("init_wr", 1'b1, 1'b1, 16'(i), 8'($urandom), 1, 1'b0);
    for (int i = 0; i < 32; i++) do_load(16'(i), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'h0100 + 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: do_write("rnd_wr", 1'b1, 1'b1, a, 8'($urandom), $urandom_range(1, 3), a >= 16'd256);
        1: do_load(a[4:0], 8'($urandom));
        2: do_read("rnd_rd", 1'b0, a);
        default: do_read("rnd_fetch", 1'b1, a[4:0]);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data_write();
    test_errors();
    test_abort();
    test_both();
    test_reset_mid();
    test_load_race();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
